// File: rtl/mul_seq.sv
// Iterative radix-2 shift-add multiplier for RISC-V mul/mulh/mulhsu/mulhu.
// The full 2*XLEN product appears XLEN+2 cycles after an accepted Start.
module mul_seq #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              Start,
  input  logic              Flush,
  input  logic [XLEN-1:0]   SrcA,
  input  logic [XLEN-1:0]   SrcB,
  input  logic [2:0]        Funct3,
  output logic              Busy,
  output logic              Done,
  output logic [2*XLEN-1:0] Prod
);

  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Two's-complement magnitude of an operand flagged as negative.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
    mag = neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] negate2(input logic [2*XLEN-1:0] v);
    negate2 = ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
  endfunction

  logic [1:0]          state_r;
  logic [CW-1:0]       cnt_r;
  logic                neg_r;
  logic [XLEN-1:0]     hi_r;
  logic [XLEN-1:0]     lo_r;
  logic [XLEN-1:0]     maga_r;
  logic [2*XLEN-1:0]   prod_r;

  logic                sign_a_s;
  logic                sign_b_s;
  logic                accept_s;
  logic [XLEN:0]       sum_s;
  logic [2*XLEN-1:0]   fixed_s;

  // Operand signedness, Start acceptance, add step and final sign fix-up.
  always_comb begin
    sign_a_s = 1'b0;
    sign_b_s = 1'b0;
    case (Funct3[1:0])
      2'b01: begin
        sign_a_s = SrcA[XLEN-1];
        sign_b_s = SrcB[XLEN-1];
      end
      2'b10: begin
        sign_a_s = SrcA[XLEN-1];
      end
      default: begin
        sign_a_s = 1'b0;
        sign_b_s = 1'b0;
      end
    endcase
    accept_s = Start && !Flush && ((state_r == S_IDLE) || (state_r == S_DONE));
    sum_s    = {1'b0, hi_r} + (lo_r[0] ? {1'b0, maga_r} : {(XLEN+1){1'b0}});
    fixed_s  = neg_r ? negate2({hi_r, lo_r}) : {hi_r, lo_r};
  end

  // Sequencer and datapath; Flush drops any in-flight work without touching Prod.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= S_IDLE;
      cnt_r   <= {CW{1'b0}};
      neg_r   <= 1'b0;
      hi_r    <= {XLEN{1'b0}};
      lo_r    <= {XLEN{1'b0}};
      maga_r  <= {XLEN{1'b0}};
      prod_r  <= {(2*XLEN){1'b0}};
    end else if (Flush) begin
      state_r <= S_IDLE;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (accept_s) begin
            state_r <= S_BUSY;
            maga_r  <= mag(SrcA, sign_a_s);
            hi_r    <= {XLEN{1'b0}};
            lo_r    <= mag(SrcB, sign_b_s);
            neg_r   <= sign_a_s ^ sign_b_s;
            cnt_r   <= {CW{1'b0}};
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_BUSY: begin
          hi_r  <= sum_s[XLEN:1];
          lo_r  <= {sum_s[0], lo_r[XLEN-1:1]};
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_r <= S_FIX;
          end else begin
            state_r <= S_BUSY;
          end
        end
        S_FIX: begin
          {hi_r, lo_r} <= fixed_s;
          prod_r       <= fixed_s;
          state_r      <= S_DONE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign Busy = (state_r == S_BUSY) || (state_r == S_FIX);
  assign Done = (state_r == S_DONE);
  assign Prod = prod_r;

endmodule

// File: tb/tb_mul_seq.sv
// Directed and reference-model checks of mul_seq at XLEN=32 and XLEN=64.
module tb_mul_seq;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         s32, f32, s64, f64;
  logic [31:0]  a32, b32;
  logic [63:0]  a64, b64;
  logic [2:0]   fn32, fn64;
  logic         busy32, done32, busy64, done64;
  logic [63:0]  prod32;
  logic [127:0] prod64;
  logic [127:0] last32, last64;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mul_seq #(.XLEN(32)) d32 (
    .clk(clk), .reset_n(reset_n), .Start(s32), .Flush(f32), .SrcA(a32), .SrcB(b32),
    .Funct3(fn32), .Busy(busy32), .Done(done32), .Prod(prod32)
  );

  mul_seq #(.XLEN(64)) d64 (
    .clk(clk), .reset_n(reset_n), .Start(s64), .Flush(f64), .SrcA(a64), .SrcB(b64),
    .Funct3(fn64), .Busy(busy64), .Done(done64), .Prod(prod64)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: sign/zero-extend into a wide product and keep the low 2*XLEN bits.
  function automatic logic [127:0] ref_mul(input bit w64, input logic [63:0] a,
                                           input logic [63:0] b, input logic [2:0] f);
    logic [127:0] ae, be, p;
    logic sa, sb;
    sa = (f[1:0] == 2'b01) || (f[1:0] == 2'b10);
    sb = (f[1:0] == 2'b01);
    if (w64) begin
      ae = (sa && a[63]) ? {{64{1'b1}}, a} : {64'd0, a};
      be = (sb && b[63]) ? {{64{1'b1}}, b} : {64'd0, b};
      p  = ae * be;
    end else begin
      ae = (sa && a[31]) ? {{96{1'b1}}, a[31:0]} : {96'd0, a[31:0]};
      be = (sb && b[31]) ? {{96{1'b1}}, b[31:0]} : {96'd0, b[31:0]};
      p  = ae * be;
      p  = {64'd0, p[63:0]};
    end
    return p;
  endfunction

  task automatic op(input bit w64, input logic [63:0] a, input logic [63:0] b,
                    input logic [2:0] f, input logic [127:0] exp, input string tag);
    int lat, nb;
    lat = 0;
    nb  = 0;
    @(negedge clk);
    if (w64) begin s64 = 1'b1; a64 = a; b64 = b; fn64 = f; end
    else begin s32 = 1'b1; a32 = a[31:0]; b32 = b[31:0]; fn32 = f; end
    @(posedge clk);
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) begin s32 = 1'b0; s64 = 1'b0; end
      if (w64 ? done64 : done32) begin lat = c; break; end
      if (w64 ? busy64 : busy32) nb++;
    end
    chk({tag, "_latency"}, lat, w64 ? 128'd66 : 128'd34);
    chk({tag, "_busycycles"}, nb, w64 ? 128'd65 : 128'd33);
    chk({tag, "_prod"}, w64 ? prod64 : {64'd0, prod32}, exp);
    if (w64) last64 = exp; else last32 = exp;
    @(negedge clk);
    chk({tag, "_donewidth"}, w64 ? done64 : done32, 128'd0);
  endtask

  initial begin
    int nb, nd, lat;
    logic [63:0] ra, rb;
    reset_n = 1'b0;
    s32 = 1'b1; f32 = 1'b0; a32 = 32'd0; b32 = 32'd0; fn32 = 3'd0;
    s64 = 1'b1; f64 = 1'b0; a64 = 64'd0; b64 = 64'd0; fn64 = 3'd0;
    last32 = 128'd0; last64 = 128'd0;

    // Reset held with Start high: never busy.
    nb = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy32 || busy64) nb++;
    end
    chk("reset_start_ignored", nb, 128'd0);
    s32 = 1'b0; s64 = 1'b0; reset_n = 1'b1;
    @(negedge clk);
    chk("reset_prod32", prod32, 128'd0);
    chk("reset_prod64", prod64, 128'd0);
    chk("reset_busy", {busy32, busy64}, 128'd0);
    chk("reset_done", {done32, done64}, 128'd0);

    op(1'b0, 64'd3, 64'd5, 3'b000, 128'hF, "mul_3x5");
    op(1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 3'b001, 128'h1, "mulh_m1m1");
    op(1'b0, 64'h8000_0000, 64'h8000_0000, 3'b001, 128'h4000_0000_0000_0000, "mulh_minmin");
    op(1'b0, 64'h8000_0000, 64'h1, 3'b001, 128'hFFFF_FFFF_8000_0000, "mulh_min1");
    op(1'b0, 64'h0, 64'hFFFF_FFF9, 3'b001, 128'h0, "mulh_0xm7");
    op(1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 3'b010, 128'hFFFF_FFFF_0000_0001, "mulhsu");
    op(1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 3'b011, 128'hFFFF_FFFE_0000_0001, "mulhu");
    op(1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 3'b101, 128'h1, "mulh_bit2_ignored");
    op(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b001, 128'h1, "mulh64_m1m1");
    op(1'b1, 64'h8000_0000_0000_0000, 64'h2, 3'b001,
       128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000, "mulh64_min2");

    // Flush mid-operation: no Done, Prod unchanged.
    @(negedge clk); s32 = 1'b1; a32 = 32'd7; b32 = 32'd9; fn32 = 3'b000;
    @(posedge clk);
    @(negedge clk); s32 = 1'b0;
    repeat (9) @(negedge clk);
    f32 = 1'b1;
    @(negedge clk); f32 = 1'b0;
    chk("flush_idle", busy32, 128'd0);
    nd = 0;
    repeat (40) begin @(negedge clk); if (done32) nd++; end
    chk("flush_no_done", nd, 128'd0);
    chk("flush_prod_kept", {64'd0, prod32}, last32);

    // Flush in the FIX cycle.
    @(negedge clk); s32 = 1'b1; a32 = 32'd3; b32 = 32'd5;
    @(posedge clk);
    @(negedge clk); s32 = 1'b0;
    repeat (32) @(negedge clk);
    chk("fix_busy", busy32, 128'd1);
    f32 = 1'b1;
    @(negedge clk); f32 = 1'b0;
    chk("fix_flush_no_done", {done32, busy32}, 128'd0);
    chk("fix_flush_prod_kept", {64'd0, prod32}, last32);

    // Reset in mid-operation clears Prod.
    @(negedge clk); s32 = 1'b1; a32 = 32'd7; b32 = 32'd9;
    @(posedge clk);
    @(negedge clk); s32 = 1'b0;
    repeat (19) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    chk("midreset_prod", prod32, 128'd0);
    chk("midreset_busy", busy32, 128'd0);
    last32 = 128'd0; last64 = 128'd0;
    op(1'b0, 64'd7, 64'd9, 3'b000, 128'd63, "after_reset");

    // Back-to-back with Start held; operand changes mid-op are ignored.
    @(negedge clk); s32 = 1'b1; a32 = 32'd2; b32 = 32'd3; fn32 = 3'b000;
    @(posedge clk);
    lat = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 5) begin a32 = 32'd9; b32 = 32'd9; end
      if (done32) begin lat = c; break; end
    end
    chk("b2b_first_latency", lat, 128'd34);
    chk("b2b_first_prod", prod32, 128'd6);
    a32 = 32'd4; b32 = 32'd5;
    lat = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) s32 = 1'b0;
      if (done32) begin lat = c; break; end
    end
    chk("b2b_second_latency", lat, 128'd34);
    chk("b2b_second_prod", prod32, 128'd20);

    // Random regression against the reference model.
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 2; k++) begin
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        op(1'b0, ra, rb, 3'(f), ref_mul(1'b0, ra, rb, 3'(f)), $sformatf("rnd32_f%0d", f));
        op(1'b1, ra, rb, 3'(f), ref_mul(1'b1, ra, rb, 3'(f)), $sformatf("rnd64_f%0d", f));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
# mul_seq

Iterative (radix-2 shift-add) integer multiplier with its own sequencing FSM. It is used in the MDU for area-constrained configurations in place of the two-stage pipelined multiplier. It accepts one RISC-V M-extension multiply per handshake and produces the full 2·XLEN-bit product after a fixed XLEN+2-cycle latency. The hazard unit uses Busy and Done to stall the pipeline and capture the result.

## Interface
- XLEN, default 32: operand width; must be a power of two, ≥ 8.
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- Start  in  1  request; sampled only when Busy=0.
- Flush  in  1  abort in-flight operation; has priority over Start.
- SrcA  in  XLEN  multiplicand (rs1); captured on accepted Start.
- SrcB  in  XLEN  multiplier (rs2); captured on accepted Start.
- Funct3  in  3  operation: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu. Bit 2 is ignored. Captured on accepted Start.
- Busy  out  1  operation in progress; new Start is ignored while high.
- Done  out  1  one-cycle pulse; Prod is valid in this cycle.
- Prod  out  2·XLEN  full product; held stable from Done until the next Done or reset.

## Operation
- **Signedness:**
  - A is signed for 001 and 010.
  - B is signed for 001 only.
  - 000 and 011 treat both operands as unsigned. The low XLEN bits are identical for all encodings.
- **Start accepted** when Start=1, Flush=0, reset_n=1 and state ∈ {IDLE, DONE}. On accept:
  - MagA=|A| and MagB=|B|, taken only for signed operands with MSB set; otherwise the raw value. For A=100…0 the magnitude is 2^(XLEN-1), held in XLEN bits unsigned.
  - NegR = signA XOR signB, registered.
  - Accumulator {Hi,Lo} = {0, MagB}.
  - Cnt = 0.
  - Next state BUSY.
- **BUSY, each cycle:**
  - Sum = Hi + (Lo[0] ? MagA : 0), computed XLEN+1 bits wide.
  - {Hi,Lo} = {Sum, Lo} >> 1.
  - Cnt++.
  - When Cnt = XLEN-1, go to FIX. Exactly XLEN iterations occur.
- **FIX, one cycle always (fixed latency):**
  - If NegR, {Hi,Lo} = ~{Hi,Lo} + 1 (2·XLEN-bit two's-complement negate).
  - Then load Prod, go to DONE.
- **DONE, one cycle:** Done=1, Busy=0. Go to BUSY if Start is accepted this cycle, else to IDLE.
- **Flush** in any state → IDLE next cycle.
  - No Done; Prod is unchanged.
  - Start in the same cycle is dropped.
- **Reset** (reset_n=0 at a clock edge, in any state, including mid-operation):
  - State IDLE; Busy=0, Done=0, Prod=0, Cnt=0, NegR=0.
  - Start is ignored during reset.
- **Arithmetic rules:**
  - Magnitude product < 2^(2·XLEN), so no overflow.
  - Negation of zero yields zero (e.g. 0 × negative → 0).
  - Signed results span the full 2·XLEN bits.
- **Encoding of state:** 2 bits. Counter width is $clog2(XLEN).

## Timing
- Start accepted at edge t (end of cycle t) → Busy=1 in cycles t+1 … t+XLEN+1 (XLEN BUSY cycles + 1 FIX cycle).
- Done=1 and Prod valid in cycle t+XLEN+2.
- Busy is combinationally high in BUSY and FIX only; Done is high in DONE only. Both are registered-state decodes with no input→output combinational path.
- Back-to-back operation: Start held high continuously yields a Done every XLEN+2 cycles.
- Operand, Funct3 and Start changes while Busy=1 have no effect.
- Flush asserted in the FIX cycle: Prod is not updated and Done is not raised.
- Flush asserted in the DONE cycle: the Done pulse still shows this cycle, and Prod keeps the new value.

## Test plan
- **Reset/idle:** After reset release, Prod=0, Busy=0 and Done=0. Hold reset_n=0 with Start=1 for 3 cycles → no Busy.
- **mul, XLEN=32:** A=3, B=5 → Busy for 33 cycles, then Done at t+34 with Prod=0x0000_0000_0000_000F. Check the Done pulse width is 1.
- **Signed corners, XLEN=32:**
  - mulh −1×−1 → Prod=0x1.
  - mulh 0x8000_0000×0x8000_0000 → 0x4000_0000_0000_0000.
  - mulh 0x8000_0000×1 → 0xFFFF_FFFF_8000_0000.
  - mulh 0×−7 → 0.
- **mulhsu/mulhu, XLEN=32:**
  - mulhsu A=0xFFFF_FFFF, B=0xFFFF_FFFF → 0xFFFF_FFFF_0000_0001.
  - mulhu same operands → 0xFFFF_FFFE_0000_0001.
- **Flush/reset mid-op:**
  - Start mul 7×9, Flush at t+10 → IDLE at t+11, no Done, Prod keeps its previous value.
  - reset_n=0 at t+20 → Prod=0.
  - A new Start afterwards completes normally.
- **Back-to-back and ignored Start:**
  - Start held high with 2×3 then 4×5 (operands changed only in the DONE cycle) → Done at t+34 (Prod=6) and t+68 (Prod=20).
  - A Start pulse with 9×9 at t+5 is ignored.
  - Random-signed regression versus a reference model for all four Funct3 values at XLEN=32 and XLEN=64.
